// File: rtl/sr_cmd_gen.sv
// Button front-end for the SR stage: 2-flop sync + debounce per button, rising-edge
// requests, and an IDLE/GAP arbiter that issues one-cycle s/r pulses with a guard gap.
`timescale 1ns/1ps
module sr_cmd_gen #(
  parameter int DEBOUNCE_CYCLES = 16,
  parameter int GAP_CYCLES      = 4
) (
  input  logic clk,
  input  logic rst_n,
  input  logic set_btn,
  input  logic clr_btn,
  output logic s,
  output logic r,
  output logic conflict,
  output logic busy
);

  localparam int CW = $clog2(DEBOUNCE_CYCLES);
  localparam int GW = $clog2(GAP_CYCLES + 1);
  localparam logic [CW-1:0] CNT_MAX  = CW'(DEBOUNCE_CYCLES - 1);
  localparam logic [GW-1:0] GAP_LOAD = GW'(GAP_CYCLES);
  localparam logic [GW-1:0] GAP_LAST = GW'(1);

  typedef enum logic {ST_IDLE, ST_GAP} state_t;

  // Channel 0 is set, channel 1 is clear.
  logic [1:0]    w_btn;
  logic [1:0]    r_sync1, r_sync2, r_deb, r_deb_q;
  logic [CW-1:0] r_cnt [2];
  logic [1:0]    w_req;

  assign w_btn = {clr_btn, set_btn};

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_sync1 <= '0;
      r_sync2 <= '0;
      r_deb   <= '0;
      r_deb_q <= '0;
      // NOTE: r_cnt is a pair of small flop counters, not RAM, so it is reset like any other state.
      for (int i = 0; i < 2; i++) r_cnt[i] <= '0;
    end else begin
      // NOTE: non-blocking assignments keep every flop sampling pre-edge values, which is what makes the sync chain two stages deep.
      r_sync1 <= w_btn;
      r_sync2 <= r_sync1;
      r_deb_q <= r_deb;
      for (int i = 0; i < 2; i++) begin
        if (r_sync2[i] == r_deb[i]) begin
          r_cnt[i] <= '0;
        end else if (r_cnt[i] == CNT_MAX) begin
          r_deb[i] <= ~r_deb[i];
          r_cnt[i] <= '0;
        end else begin
          r_cnt[i] <= r_cnt[i] + 1'b1;
        end
      end
    end
  end

  assign w_req = r_deb & ~r_deb_q;

  state_t        r_state, w_state_nxt;
  logic [GW-1:0] r_gap_cnt, w_gap_nxt;
  logic          r_pend_s, r_pend_r, w_pend_s_nxt, w_pend_r_nxt;
  logic          r_s_pulse, r_r_pulse, r_conf_pulse;
  logic          w_s_nxt, w_r_nxt, w_conf_nxt;
  logic          w_eff_s, w_eff_r;

  assign w_eff_s = w_req[0] | r_pend_s;
  assign w_eff_r = w_req[1] | r_pend_r;

  always_comb begin
    // NOTE: every output of this block gets a default first so no path can infer a latch.
    w_state_nxt  = r_state;
    w_gap_nxt    = r_gap_cnt;
    w_pend_s_nxt = r_pend_s;
    w_pend_r_nxt = r_pend_r;
    w_s_nxt      = 1'b0;
    w_r_nxt      = 1'b0;
    w_conf_nxt   = 1'b0;
    case (r_state)
      ST_IDLE: begin
        w_pend_s_nxt = 1'b0;
        w_pend_r_nxt = 1'b0;
        if (w_eff_s && w_eff_r) begin
          w_conf_nxt = 1'b1;
        end else if (w_eff_s || w_eff_r) begin
          w_s_nxt     = w_eff_s;
          w_r_nxt     = w_eff_r;
          w_state_nxt = ST_GAP;
          w_gap_nxt   = GAP_LOAD;
        end
      end
      ST_GAP: begin
        w_gap_nxt = r_gap_cnt - 1'b1;
        if (r_gap_cnt == GAP_LAST) w_state_nxt = ST_IDLE;
        // Latest request wins the pending slot; a same-cycle pair cancels it.
        if (w_req[0] && w_req[1]) begin
          w_pend_s_nxt = 1'b0;
          w_pend_r_nxt = 1'b0;
          w_conf_nxt   = 1'b1;
        end else if (w_req[0]) begin
          w_pend_s_nxt = 1'b1;
          w_pend_r_nxt = 1'b0;
        end else if (w_req[1]) begin
          w_pend_s_nxt = 1'b0;
          w_pend_r_nxt = 1'b1;
        end
      end
      default: w_state_nxt = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_state      <= ST_IDLE;
      r_gap_cnt    <= '0;
      r_pend_s     <= 1'b0;
      r_pend_r     <= 1'b0;
      r_s_pulse    <= 1'b0;
      r_r_pulse    <= 1'b0;
      r_conf_pulse <= 1'b0;
    end else begin
      r_state      <= w_state_nxt;
      r_gap_cnt    <= w_gap_nxt;
      r_pend_s     <= w_pend_s_nxt;
      r_pend_r     <= w_pend_r_nxt;
      r_s_pulse    <= w_s_nxt;
      r_r_pulse    <= w_r_nxt;
      r_conf_pulse <= w_conf_nxt;
    end
  end

  assign s        = r_s_pulse;
  assign r        = r_r_pulse;
  assign conflict = r_conf_pulse;
  assign busy     = (r_state == ST_GAP);

endmodule

// File: tb/tb_sr_cmd_gen.sv
// Scoreboard bench for sr_cmd_gen: a default instance (16/4) and a fast instance (2/16)
// used for the pending-replacement and in-gap conflict cases.
`timescale 1ns/1ps
module tb_sr_cmd_gen;

  localparam int D  = 16;
  localparam int G  = 4;
  localparam int FD = 2;
  localparam int FG = 16;

  localparam logic [2:0] K_S = 3'b001;
  localparam logic [2:0] K_R = 3'b010;
  localparam logic [2:0] K_C = 3'b100;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  logic set_btn = 1'b0, clr_btn = 1'b0, set_f = 1'b0, clr_f = 1'b0;
  logic s, r, conflict, busy;
  logic s_f, r_f, conflict_f, busy_f;

  int cyc = 0;
  int total = 0;
  int bad = 0;

  typedef struct {
    logic [2:0] kind;
    int         at;
  } ev_t;

  ev_t q_main[$];
  ev_t q_fast[$];
  ev_t e_main, e_fast;

  sr_cmd_gen #(.DEBOUNCE_CYCLES(D), .GAP_CYCLES(G)) u_dut (
    .clk(clk), .rst_n(rst_n), .set_btn(set_btn), .clr_btn(clr_btn),
    .s(s), .r(r), .conflict(conflict), .busy(busy)
  );

  sr_cmd_gen #(.DEBOUNCE_CYCLES(FD), .GAP_CYCLES(FG)) u_dut_fast (
    .clk(clk), .rst_n(rst_n), .set_btn(set_f), .clr_btn(clr_f),
    .s(s_f), .r(r_f), .conflict(conflict_f), .busy(busy_f)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  // Pulses are popped against the expected queue at the falling edge; cyc equals the edge that launched them.
  always @(negedge clk) begin
    if (s === 1'b1 || r === 1'b1 || conflict === 1'b1) begin
      total++;
      if (q_main.size() == 0) begin
        bad++;
        $display("FAIL main_unexpected: kind=%b at cycle %0d, required no pulse", {conflict, r, s}, cyc);
      end else begin
        e_main = q_main.pop_front();
        if ({conflict, r, s} !== e_main.kind || cyc != e_main.at) begin
          bad++;
          $display("FAIL main_pulse: kind=%b at cycle %0d, required kind=%b at cycle %0d",
                   {conflict, r, s}, cyc, e_main.kind, e_main.at);
        end
      end
    end
  end

  always @(negedge clk) begin
    if (s_f === 1'b1 || r_f === 1'b1 || conflict_f === 1'b1) begin
      total++;
      if (q_fast.size() == 0) begin
        bad++;
        $display("FAIL fast_unexpected: kind=%b at cycle %0d, required no pulse", {conflict_f, r_f, s_f}, cyc);
      end else begin
        e_fast = q_fast.pop_front();
        if ({conflict_f, r_f, s_f} !== e_fast.kind || cyc != e_fast.at) begin
          bad++;
          $display("FAIL fast_pulse: kind=%b at cycle %0d, required kind=%b at cycle %0d",
                   {conflict_f, r_f, s_f}, cyc, e_fast.kind, e_fast.at);
        end
      end
    end
  end

  task automatic wait_cyc(input int target);
    while (cyc < target) @(negedge clk);
  endtask

  task automatic drain_check(input string name);
    total++;
    if (q_main.size() != 0 || q_fast.size() != 0) begin
      bad++;
      $display("FAIL %s_missing: outstanding main=%0d fast=%0d, required 0 and 0", name, q_main.size(), q_fast.size());
    end
    q_main.delete();
    q_fast.delete();
  endtask

  task automatic test_reset();
    rst_n = 1'b0;
    for (int k = 0; k < 3; k++) begin
      @(negedge clk);
      set_btn = k[0];
      clr_btn = ~k[0];
      set_f   = ~k[0];
      clr_f   = k[0];
      total++;
      if ({s, r, conflict, busy, s_f, r_f, conflict_f, busy_f} !== 8'h00) begin
        bad++;
        $display("FAIL reset_hold: outputs=%b, required 00000000", {s, r, conflict, busy, s_f, r_f, conflict_f, busy_f});
      end
    end
    @(negedge clk);
    {set_btn, clr_btn, set_f, clr_f} = 4'b0000;
    rst_n = 1'b1;
    @(negedge clk);
    total++;
    if ({s, r, conflict, busy, s_f, r_f, conflict_f, busy_f} !== 8'h00) begin
      bad++;
      $display("FAIL reset_release: outputs=%b, required 00000000", {s, r, conflict, busy, s_f, r_f, conflict_f, busy_f});
    end
  endtask

  task automatic test_debounced_set();
    int  t0;
    logic exp_busy;
    @(negedge clk);
    t0 = cyc + 1;
    set_btn = 1'b1;
    q_main.push_back('{K_S, t0 + D + 2});
    for (int k = D + 1; k <= D + 2 + G; k++) begin
      wait_cyc(t0 + k);
      exp_busy = (k >= D + 2) && (k < D + 2 + G);
      total++;
      if (busy !== exp_busy) begin
        bad++;
        $display("FAIL set_busy: busy=%b at offset %0d, required %b", busy, k, exp_busy);
      end
    end
    set_btn = 1'b0;
    wait_cyc(cyc + D + 8);
    drain_check("debounced_set");
  endtask

  task automatic test_bounce();
    int t0, t1;
    @(negedge clk);
    t0 = cyc + 1;
    clr_btn = 1'b1;
    wait_cyc(t0 + D - 2);
    clr_btn = 1'b0;
    wait_cyc(t0 + D + 8);
    drain_check("bounce_reject");
    t1 = cyc + 1;
    clr_btn = 1'b1;
    q_main.push_back('{K_R, t1 + D + 2});
    wait_cyc(t1 + D - 1);
    clr_btn = 1'b0;
    wait_cyc(t1 + 2 * D + 8);
    drain_check("bounce_accept");
  endtask

  task automatic test_simultaneous();
    int t0;
    @(negedge clk);
    t0 = cyc + 1;
    set_btn = 1'b1;
    clr_btn = 1'b1;
    q_main.push_back('{K_C, t0 + D + 2});
    for (int k = D + 2; k <= D + 3; k++) begin
      wait_cyc(t0 + k);
      total++;
      if (busy !== 1'b0) begin
        bad++;
        $display("FAIL simul_busy: busy=%b at offset %0d, required 0", busy, k);
      end
    end
    {set_btn, clr_btn} = 2'b00;
    wait_cyc(cyc + D + 8);
    drain_check("simultaneous");
  endtask

  task automatic test_pending();
    int t0, e;
    @(negedge clk);
    t0 = cyc + 1;
    e  = t0 + D + 2;
    set_btn = 1'b1;
    q_main.push_back('{K_S, e});
    q_main.push_back('{K_R, e + G + 1});
    wait_cyc(t0 + 1);
    clr_btn = 1'b1;
    wait_cyc(e + G - 1);
    total++;
    if (busy !== 1'b1) begin
      bad++;
      $display("FAIL pend_busy_last: busy=%b, required 1", busy);
    end
    wait_cyc(e + G);
    total++;
    if (busy !== 1'b0) begin
      bad++;
      $display("FAIL pend_busy_idle: busy=%b, required 0", busy);
    end
    {set_btn, clr_btn} = 2'b00;
    wait_cyc(cyc + D + 10);
    drain_check("pending");
  endtask

  task automatic test_reset_mid_gap();
    int t0, e;
    @(negedge clk);
    t0 = cyc + 1;
    e  = t0 + D + 2;
    set_btn = 1'b1;
    q_main.push_back('{K_S, e});
    wait_cyc(t0 + 1);
    clr_btn = 1'b1;
    wait_cyc(e + 2);
    {set_btn, clr_btn} = 2'b00;
    rst_n = 1'b0;
    wait_cyc(e + 3);
    rst_n = 1'b1;
    total++;
    if (busy !== 1'b0) begin
      bad++;
      $display("FAIL midgap_busy: busy=%b after reset, required 0", busy);
    end
    wait_cyc(e + D + 12);
    drain_check("reset_mid_gap");
  endtask

  task automatic test_latest_wins();
    int t0, e;
    @(negedge clk);
    t0 = cyc + 1;
    e  = t0 + FD + 2;
    q_fast.push_back('{K_S, e});
    q_fast.push_back('{K_S, e + FG + 1});
    for (int k = 0; k < 40; k++) begin
      set_f = (k < 2) || (k >= 8 && k < 10);
      clr_f = (k >= 3 && k < 5);
      if (cyc == e + FG - 1 || cyc == e + FG) begin
        total++;
        if (busy_f !== (cyc == e + FG - 1)) begin
          bad++;
          $display("FAIL latest_busy: busy=%b at cycle %0d, required %b", busy_f, cyc, (cyc == e + FG - 1));
        end
      end
      @(negedge clk);
    end
    drain_check("latest_wins");
  endtask

  task automatic test_gap_conflict();
    int t0, e;
    @(negedge clk);
    t0 = cyc + 1;
    e  = t0 + FD + 2;
    q_fast.push_back('{K_R, e});
    q_fast.push_back('{K_C, e + 8});
    for (int k = 0; k < 40; k++) begin
      clr_f = (k < 2) || (k >= 8 && k < 10);
      set_f = (k >= 1 && k < 3) || (k >= 8 && k < 10);
      if (cyc == e + 9) begin
        total++;
        if (busy_f !== 1'b1) begin
          bad++;
          $display("FAIL gapconf_busy: busy=%b at cycle %0d, required 1", busy_f, cyc);
        end
      end
      @(negedge clk);
    end
    drain_check("gap_conflict");
  endtask

  initial begin
    test_reset();
    test_debounced_set();
    test_bounce();
    test_simultaneous();
    test_pending();
    test_reset_mid_gap();
    test_latest_wins();
    test_gap_conflict();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation exceeded time limit at cycle %0d, required completion", cyc);
    $fatal(1);
  end

endmodule

// File: doc/sr_cmd_gen.md
# sr_cmd_gen

Command front-end that feeds the SR flip-flop stage. Takes two raw, asynchronous, bouncy push-button lines (set request, clear request), synchronizes and debounces each, converts debounced rising edges into single-cycle `s`/`r` command pulses, and arbitrates so the downstream flip-flop never sees `s` and `r` high together. Commands are spaced by an enforced guard gap. Requests arriving during the gap are held in a one-deep pending slot.

## Interface
- `DEBOUNCE_CYCLES`, default 16: consecutive cycles a synchronized input must differ from its debounced level before the new level is accepted. Legal range ≥ 2.
- `GAP_CYCLES`, default 4: guard cycles after each issued command, during which no new command is issued. Legal range ≥ 1.
- `clk` input, 1 bit: clock, rising edge.
- `rst_n` input, 1 bit: reset, synchronous, active-low.
- `set_btn` input, 1 bit: raw set request. Asynchronous, active-high, may bounce.
- `clr_btn` input, 1 bit: raw clear request. Asynchronous, active-high, may bounce.
- `s` output, 1 bit: registered one-cycle set pulse to the SR stage.
- `r` output, 1 bit: registered one-cycle reset pulse to the SR stage.
- `conflict` output, 1 bit: registered one-cycle pulse when simultaneous set and clear requests were discarded.
- `busy` output, 1 bit: high while the arbiter is in GAP.

## Operation
- **Reset (`rst_n` = 0 at a clk edge).**
  - Clears to 0: synchronizer flops, debounced levels, debounce counters, edge-detect history, pending slot and gap counter.
  - FSM returns to IDLE.
  - `s`, `r`, `conflict` and `busy` are all 0.
  - Reset asserted mid-gap or with a request pending discards everything; no pulse is emitted afterwards for that request.
- **Synchronizer.** Each button passes through a 2-flop synchronizer.
- **Debounce, per channel.**
  - Counter clears whenever the synced value equals the debounced level.
  - Otherwise the counter increments.
  - When the counter reaches DEBOUNCE_CYCLES−1 while still differing, the debounced level toggles and the counter clears.
  - Any glitch shorter than DEBOUNCE_CYCLES cycles is rejected.
- **Request.** A request is the debounced level being 1 while its previous-cycle value was 0. It lasts one cycle. Falling edges generate nothing.
- **FSM states:** IDLE and GAP.
- **IDLE.**
  - Effective request per channel = new request OR pending bit.
  - Only set effective: `s` = 1 next cycle, pending cleared, go to GAP.
  - Only clear effective: `r` = 1 next cycle, pending cleared, go to GAP.
  - Both effective: neither `s` nor `r`, `conflict` = 1 next cycle, pending cleared, stay IDLE.
  - Neither effective: stay IDLE.
- **GAP.**
  - Gap counter loads GAP_CYCLES on entry and decrements each cycle. Return to IDLE when it reaches 0.
  - A new request during GAP is stored in the pending slot: pending = {channel}, replacing any opposite pending entry (latest wins).
  - Both new requests in the same GAP cycle: pending cleared and `conflict` pulses.
  - `busy` = 1 exactly while in GAP.
- **Invariants.**
  - `s` & `r` is never 1.
  - `s`, `r` and `conflict` are each 1 for exactly one cycle per event.

## Timing
- **Input-to-pulse latency.** Count edge 0 as the first clk edge that samples a clean high on the button.
  - Debounced level rises at edge DEBOUNCE_CYCLES+1.
  - `s`/`r` is high in the cycle after edge DEBOUNCE_CYCLES+2, i.e. DEBOUNCE_CYCLES+3 cycles of latency, when the arbiter is idle.
- **Command spacing.** If a command is issued at edge E:
  - `busy` is high from edge E through edge E+GAP_CYCLES−1, and low from edge E+GAP_CYCLES.
  - A pending request is issued at edge E+GAP_CYCLES+1.
  - Minimum spacing between pulses is GAP_CYCLES+1 cycles.
- **Same-cycle collision in IDLE.** A request arriving in the same cycle the FSM returns to IDLE is treated identically to a pending request.
- **Release.** Button release produces no output. Re-press requires a full debounced low then high.

## Test plan
- **Reset.** Hold `rst_n` = 0 for 3 cycles while toggling both buttons -> `s` = `r` = `conflict` = `busy` = 0 throughout and on the first cycle after release.
- **Debounced set.** DEBOUNCE_CYCLES=16, GAP=4. Press `set_btn` clean -> single `s` pulse exactly 19 cycles after the first sampling edge; `busy` high 4 cycles; no `r`.
- **Bounce rejection.** `clr_btn` glitches high for 15 cycles, then low -> no `r`. A subsequent 16-cycle hold -> one `r` pulse.
- **Simultaneous press.** Both buttons rise on the same edge -> `conflict` pulses once, no `s`/`r`, `busy` stays 0.
- **Pending during gap.** `s` issued at edge E; clear request arrives at E+2 -> `r` pulses at E+5 (GAP=4). If a set request then arrives at E+3 instead, it replaces the clear: `s` pulses at E+5.
- **Reset mid-gap.** Request pending in GAP, then `rst_n` = 0 for 1 cycle -> no further pulse, `busy` = 0 the cycle after reset.
